rr_arbiter_8: RTL and testbench

Round-robin arbiter that shares one resource among 8 requesters. It issues a registered one-hot grant, a 3-bit encoded grant index and a valid flag. Optional hold-limit preemption stops any single requester from monopolising the resource. It sits in front of the shared datapath: `grant_idx` drives the datapath select, and `grant` returns to the requesters.

---
 rtl/arb_pkg.sv | 13 +
 rtl/rr_pick_8.sv | 31 +++
 rtl/rr_arbiter_8.sv | 101 ++++++++++
 tb/tb_rr_arbiter_8.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants and state type for the 8-way round-robin arbiter
package arb_pkg;

  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;
  localparam int HOLD_W    = 8;

  typedef enum logic {
    ST_IDLE,
    ST_GRANT
  } arb_state_t;

endpackage

// File: rtl/rr_pick_8.sv
// rtl/rr_pick_8.sv - combinational rotating-priority picker, highest priority at ptr
module rr_pick_8
  import arb_pkg::*;
(
  input  logic [ARB_N-1:0]     req,
  input  logic [ARB_IDX_W-1:0] ptr,
  output logic [ARB_N-1:0]     onehot,
  output logic [ARB_IDX_W-1:0] idx,
  output logic                 any
);

  logic [ARB_N-1:0]     rot;
  logic [ARB_N-1:0]     rot_sel;
  logic [ARB_IDX_W-1:0] rot_idx;

  always_comb begin
    // rot[k] holds req[(ptr + k) mod 8], so bit 0 is the current top priority
    rot     = ARB_N'(({req, req}) >> ptr);
    rot_sel = rot & (~rot + ARB_N'(1));
    rot_idx = '0;
    for (int k = ARB_N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        rot_idx = ARB_IDX_W'(k);
      end
    end
    onehot = ARB_N'((({rot_sel, rot_sel}) << ptr) >> ARB_N);
    idx    = rot_idx + ptr;
    any    = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-requester round-robin arbiter with registered grant and hold-limit preemption
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic [ARB_N-1:0]     req,
  output logic [ARB_N-1:0]     grant,
  output logic [ARB_IDX_W-1:0] grant_idx,
  output logic                 grant_valid,
  output logic                 preempt
);

  localparam bit                PREEMPT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST  = (MAX_HOLD == 0) ? '0 : HOLD_W'(MAX_HOLD - 1);

  arb_state_t           state, state_nx;
  logic [ARB_IDX_W-1:0] ptr, ptr_nx;
  logic [HOLD_W-1:0]    hold_cnt, hold_nx;
  logic [ARB_N-1:0]     grant_nx;
  logic [ARB_IDX_W-1:0] idx_nx;
  logic                 valid_nx;
  logic                 preempt_nx;

  logic [ARB_N-1:0]     pick_onehot;
  logic [ARB_IDX_W-1:0] pick_idx;
  logic                 pick_any;

  rr_pick_8 u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_nx   = state;
    grant_nx   = grant;
    idx_nx     = grant_idx;
    valid_nx   = grant_valid;
    preempt_nx = 1'b0;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    case (state)
      ST_IDLE: begin
        if (enable && pick_any) begin
          grant_nx = pick_onehot;
          idx_nx   = pick_idx;
          valid_nx = 1'b1;
          hold_nx  = '0;
          state_nx = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req[grant_idx]) begin
          grant_nx = '0;
          valid_nx = 1'b0;
          ptr_nx   = grant_idx + ARB_IDX_W'(1);
          state_nx = ST_IDLE;
        end else if (PREEMPT_EN && (hold_cnt == HOLD_LAST) && |(req & ~grant)) begin
          // revoke only when someone else is actually waiting
          grant_nx   = '0;
          valid_nx   = 1'b0;
          preempt_nx = 1'b1;
          ptr_nx     = grant_idx + ARB_IDX_W'(1);
          state_nx   = ST_IDLE;
        end else if (hold_cnt != '1) begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      grant_valid <= 1'b0;
      preempt     <= 1'b0;
      ptr         <= '0;
      hold_cnt    <= '0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      grant_idx   <= idx_nx;
      grant_valid <= valid_nx;
      preempt     <= preempt_nx;
      ptr         <= ptr_nx;
      hold_cnt    <= hold_nx;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - randomized and directed bench for rr_arbiter_8 against a behavioural model
module tb_rr_arbiter_8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  int n_checks = 0;
  int n_errors = 0;

  // model state: owner -1 means nobody holds the resource
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_idx   = 0;
  int m_pre   = 0;

  rr_arbiter_8 #(.MAX_HOLD(MH)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .req         (req),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid),
    .preempt     (preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_ptr = 0; m_hold = 0; m_idx = 0; m_pre = 0;
  endtask

  task automatic model_step();
    int others;
    m_pre = 0;
    if (m_owner < 0) begin
      if (enable && req != 8'h00) begin
        for (int k = 0; k < 8; k++) begin
          if (req[(m_ptr + k) % 8]) begin
            m_owner = (m_ptr + k) % 8;
            break;
          end
        end
        m_idx  = m_owner;
        m_hold = 0;
      end
    end else begin
      others = 0;
      for (int i = 0; i < 8; i++) if (i != m_owner && req[i]) others++;
      if (!req[m_owner]) begin
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (MH != 0 && m_hold == MH - 1 && others > 0) begin
        m_pre   = 1;
        m_ptr   = (m_owner + 1) % 8;
        m_owner = -1;
      end else if (m_hold < 255) begin
        m_hold++;
      end
    end
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, ".grant"},   grant,       (m_owner < 0) ? 0 : (1 << m_owner));
    check({pfx, ".idx"},     grant_idx,   m_idx);
    check({pfx, ".valid"},   grant_valid, (m_owner < 0) ? 0 : 1);
    check({pfx, ".preempt"}, preempt,     m_pre);
  endtask

  task automatic step(input string pfx);
    @(posedge clk);
    model_step();
    #1;
    compare_all(pfx);
  endtask

  // asynchronous reset pulse placed between clock edges
  task automatic do_reset(input string pfx);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all(pfx);
    rst = 1'b0;
  endtask

  initial begin
    int run_len;
    int age;
    int bad;
    int pres;
    logic prev_valid;
    int order[$];

    do_reset("rst0");

    // reset in the middle of a grant
    enable = 1'b1; req = 8'h04;
    step("rg0");
    check("rg_grant", grant, 8'h04);
    step("rg1");
    do_reset("rg_rst");
    req = 8'h00;
    step("rg2");
    req = 8'h01;
    step("rg3");
    check("rg_after_grant", grant, 8'h01);
    check("rg_after_idx", grant_idx, 3'd0);

    // rotation with every requester asking
    do_reset("rot_rst");
    req = 8'hFF; age = 0; prev_valid = 1'b0;
    for (int c = 0; c < 80 && order.size() < 9; c++) begin
      step("rot");
      if (grant_valid && !prev_valid) order.push_back(grant_idx);
      prev_valid = grant_valid;
      if (m_owner >= 0) begin
        age++;
        req = (age >= 2) ? (8'hFF & ~(8'h01 << m_owner)) : 8'hFF;
      end else begin
        age = 0;
        req = 8'hFF;
      end
    end
    check("rot_count", order.size(), 9);
    for (int i = 0; i < order.size(); i++) check("rot_order", order[i], i % 8);

    // wrap-around from ptr 6
    do_reset("wrap_rst");
    req = 8'h20; step("wrap0");
    req = 8'h00; step("wrap1");
    req = 8'h03; step("wrap2");
    check("wrap_grant", grant, 8'h01);
    check("wrap_idx", grant_idx, 3'd0);
    req = 8'h00; step("wrap3");
    req = 8'h03; step("wrap4");
    check("wrap_ptr1_grant", grant, 8'h02);

    // hold-limit preemption under contention
    do_reset("pre_rst");
    req = 8'h09; run_len = 0;
    for (int c = 0; c < 12; c++) begin
      step("pre");
      if (grant == 8'h01) run_len++;
      if (preempt) break;
    end
    check("pre_fired", preempt, 1'b1);
    check("pre_len", run_len, MH);
    check("pre_grant_zero", grant, 8'h00);
    step("pre_idle");
    check("pre_next_grant", grant, 8'h08);
    check("pre_next_idx", grant_idx, 3'd3);

    // sole requester never preempted
    do_reset("solo_rst");
    req = 8'h01; bad = 0; pres = 0;
    step("solo0");
    for (int c = 0; c < 20; c++) begin
      step("solo");
      if (grant != 8'h01) bad++;
      if (preempt) pres++;
    end
    check("solo_grant_drop", bad, 0);
    check("solo_preempt", pres, 0);

    // enable gating
    do_reset("en_rst");
    enable = 1'b0; req = 8'h10;
    for (int c = 0; c < 3; c++) step("en_off");
    check("en_off_grant", grant, 8'h00);
    enable = 1'b1;
    step("en_on");
    check("en_on_grant", grant, 8'h10);
    enable = 1'b0;
    for (int c = 0; c < 6; c++) step("en_hold");
    check("en_hold_grant", grant, 8'h10);
    req = 8'h00;
    step("en_rel");
    check("en_rel_grant", grant, 8'h00);

    // random traffic with occasional asynchronous reset
    enable = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 8; i++) if ($urandom_range(7) == 0) req[i] = ~req[i];
      enable = ($urandom_range(9) != 0);
      step("rnd");
      if ($urandom_range(299) == 0) do_reset("rnd_rst");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
